// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, 7/8 data bits LSB first, optional even parity,
// 1/2 stop bits, with the frame format captured at acceptance.
module uart_transmitter #(
    parameter int DIV_SLOW = 32,
    parameter int DIV_FAST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       tx_start,
    input  logic       dnum,
    input  logic       snum,
    input  logic       par,
    input  logic       bd_rate,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW      = $clog2(DIV_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity over the data bits actually sent (bit 7 only in 8-bit mode).
    function automatic logic even_parity(input logic [7:0] d, input logic eight);
        return (^d[6:0]) ^ (eight & d[7]);
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [2:0]      bit_cnt_r, bit_cnt_s;
    logic [7:0]      shift_r, shift_s;
    logic            dnum_r, dnum_s;
    logic            snum_r, snum_s;
    logic            par_r, par_s;
    logic            bd_r, bd_s;
    logic            par_bit_r, par_bit_s;
    logic            tx_r, tx_s;
    logic            done_r, done_s;
    logic            ready_r, ready_s;
    logic [CW-1:0]   lim_s;
    logic            bit_end_s;

    // Next-state, shadow-register and output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        dnum_s    = dnum_r;
        snum_s    = snum_r;
        par_s     = par_r;
        bd_s      = bd_r;
        par_bit_s = par_bit_r;
        tx_s      = tx_r;
        done_s    = 1'b0;
        lim_s     = bd_r ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
        bit_end_s = (cnt_r == lim_s);

        if (state_r == IDLE) begin
            cnt_s = '0;
        end else if (bit_end_s) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end

        case (state_r)
            IDLE: begin
                bit_cnt_s = 3'd0;
                tx_s      = 1'b1;
                if (tx_start) begin
                    shift_s   = data_in;
                    dnum_s    = dnum;
                    snum_s    = snum;
                    par_s     = par;
                    bd_s      = bd_rate;
                    par_bit_s = even_parity(data_in, dnum);
                    state_s   = START;
                    tx_s      = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == (dnum_r ? 3'd7 : 3'd6)) begin
                        bit_cnt_s = 3'd0;
                        if (par_r) begin
                            state_s = PARITY;
                            tx_s    = par_bit_r;
                        end else begin
                            state_s = STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = shift_r[1];
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_s   = STOP;
                    bit_cnt_s = 3'd0;
                    tx_s      = 1'b1;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                tx_s = 1'b1;
                // bit_cnt counts completed stop bits here
                if (bit_end_s) begin
                    if (bit_cnt_r == {2'b00, snum_r}) begin
                        state_s   = IDLE;
                        bit_cnt_s = 3'd0;
                        done_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                tx_s    = 1'b1;
            end
        endcase

        ready_s = (state_s == IDLE);
    end

    // State, counters, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            dnum_r    <= 1'b0;
            snum_r    <= 1'b0;
            par_r     <= 1'b0;
            bd_r      <= 1'b0;
            par_bit_r <= 1'b0;
            tx_r      <= 1'b1;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            dnum_r    <= dnum_s;
            snum_r    <= snum_s;
            par_r     <= par_s;
            bd_r      <= bd_s;
            par_bit_r <= par_bit_s;
            tx_r      <= tx_s;
            done_r    <= done_s;
            ready_r   <= ready_s;
        end
    end

    assign tx       = tx_r;
    assign tx_done  = done_r;
    assign tx_ready = ready_r;
    assign tx_busy  = ~ready_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed frames plus random frames,
// compared cycle by cycle against a bit-list model of the frame.
module tb_uart_transmitter;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       tx_start;
    logic       dnum;
    logic       snum;
    logic       par;
    logic       bd_rate;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    uart_transmitter #(.DIV_SLOW(32), .DIV_FAST(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .tx_start (tx_start),
        .dnum     (dnum),
        .snum     (snum),
        .par      (par),
        .bd_rate  (bd_rate),
        .tx       (tx),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx, 1'b1);
        check({tag, "_ready"}, tx_ready, 1'b1);
        check({tag, "_busy"}, tx_busy, 1'b0);
        check({tag, "_done"}, tx_done, 1'b0);
    endtask

    // Called just after a negedge. Starts a frame and checks it cycle by cycle.
    // disturb_at: cycle index at which inputs are scrambled and tx_start pulsed (-1 none).
    // rst_at: cycle index at which reset is asserted, aborting the frame (-1 none).
    task automatic run_frame(input logic [7:0] d, input logic dn, input logic sn,
                             input logic pa, input logic bd, input bit hold,
                             input int disturb_at, input int rst_at);
        bit q[$];
        int ones;
        int n;
        n = bd ? 16 : 32;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < (dn ? 8 : 7); i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pa) q.push_back(bit'(ones % 2));
        for (int i = 0; i < (sn ? 2 : 1); i++) q.push_back(1'b1);

        data_in  = d;
        dnum     = dn;
        snum     = sn;
        par      = pa;
        bd_rate  = bd;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;

        for (int j = 0; j < n * q.size(); j++) begin
            @(negedge clk);
            check("frame_tx", tx, q[j / n]);
            check("frame_busy", tx_busy, 1'b1);
            check("frame_ready", tx_ready, 1'b0);
            check("frame_done", tx_done, 1'b0);
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle("after_rst");
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    check_idle("post_rst_quiet");
                end
                return;
            end
            if (j == disturb_at) begin
                data_in  = ~d;
                bd_rate  = ~bd;
                par      = ~pa;
                dnum     = ~dn;
                snum     = ~sn;
                tx_start = 1'b1;
            end else if (j == disturb_at + 1 && !hold) begin
                tx_start = 1'b0;
            end
        end
        @(negedge clk);
        check("end_tx", tx, 1'b1);
        check("end_done", tx_done, 1'b1);
        check("end_ready", tx_ready, 1'b1);
        check("end_busy", tx_busy, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = 8'h00;
        tx_start = 1'b0;
        dnum     = 1'b1;
        snum     = 1'b0;
        par      = 1'b0;
        bd_rate  = 1'b1;

        // 1: reset values and quiet idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // 2: 8N1 fast, 0xA5
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        @(negedge clk);
        check_idle("gap2");

        // 3: 7 bits, even parity, 2 stop, slow, 0xFF
        run_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        check_idle("gap3");

        // 4: tx_start held high, back-to-back frames
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        run_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        tx_start = 1'b0;
        @(negedge clk);
        check_idle("gap4");

        // 5: inputs scrambled and tx_start pulsed mid-frame
        run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 70, -1);
        @(negedge clk);
        check_idle("gap5");

        // 6: reset during the 3rd data bit, then a clean frame
        run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 52);
        run_frame(8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
        @(negedge clk);
        check_idle("gap6");

        // Random frames with random idle gaps
        for (int r = 0; r < 12; r++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'b0, -1, -1);
            for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
                @(negedge clk);
                check_idle("rand_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmit stage. It is the upstream partner of the UART receiver and drives the serial line that the receiver samples. It accepts one byte per handshake and serialises it: start bit, 7 or 8 data bits LSB first, optional even parity bit, then 1 or 2 stop bits. Frame format and baud select use the same configuration inputs as the receiver (dnum, snum, par, bd_rate), so both ends can share one configuration.

Parameters:
DIV_SLOW, 32, clk cycles per bit when bd_rate=0 (must be >= 2)
DIV_FAST, 16, clk cycles per bit when bd_rate=1 (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  8  byte to send; bit 0 goes out first
tx_start  input  1  request to send data_in; accepted only when tx_ready=1
dnum  input  1  0: 7 data bits (data_in[7] ignored), 1: 8 data bits
snum  input  1  0: 1 stop bit, 1: 2 stop bits
par  input  1  0: no parity bit, 1: even parity bit after the data bits
bd_rate  input  1  0: DIV_SLOW, 1: DIV_FAST
tx  output  1  serial line, idles high, registered
tx_ready  output  1  high in IDLE; a start is accepted when tx_start&&tx_ready
tx_busy  output  1  high from the cycle after acceptance until the frame ends
tx_done  output  1  one-cycle pulse when the last stop bit period completes

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters=0.
- States are IDLE, START, DATA, PARITY, STOP.
- Acceptance edge E0: the edge where state=IDLE and tx_start=1.
  - At E0 the block latches data_in, dnum, snum, par and bd_rate into a shadow register.
  - Changes to these inputs during a frame have no effect on that frame.
- Bit timing, with N = DIV_FAST if the latched bd_rate=1, else DIV_SLOW:
  - Each bit holds tx for exactly N clk cycles.
  - Bit k (k=0 is the start bit) is driven after edge E0+N*k.
  - Total frame length F = 1 + D + P + S bits, where D = 7 or 8, P = 0 or 1, S = 1 or 2.
- Transitions:
  - IDLE -> START at E0; tx=0.
  - START -> DATA after N cycles.
  - DATA shifts the latched byte right and sends D bits. After the D-th bit it goes to PARITY if par=1, else to STOP.
  - PARITY drives the XOR of the D data bits (even parity: total count of ones in data+parity is even), for N cycles, then goes to STOP.
  - STOP drives tx=1 for S*N cycles, then returns to IDLE.
- At edge E0+N*F:
  - state becomes IDLE, tx=1, tx_busy=0, tx_ready=1.
  - tx_done=1 for exactly that one cycle.
- Back-to-back frames: tx_start may be high in the tx_done cycle and is accepted there. The line is then high for exactly one clk cycle between the end of the last stop bit and the next start bit.
- A tx_start while tx_ready=0 is ignored: no queuing and no error. The frame in progress is unaffected.
- Bit-period counter:
  - Width is ceil(log2(max(DIV_SLOW, DIV_FAST))).
  - Counts 0..N-1 and wraps to 0 at each bit boundary.
  - Separate bit counter 0..7 for data bits.
- Reset asserted mid-frame: on the next edge the block returns to reset values. tx=1 immediately after that edge. No tx_done pulse is produced.
- tx_busy and tx_ready are always complements.

Test Plan:
1. rst=1 for 3 cycles, then 0 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0; line stays high with tx_start=0 for 100 cycles.
2. bd_rate=1, dnum=1, snum=0, par=0, data_in=8'hA5, pulse tx_start at E0 -> tx=0 for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles; tx_done pulses one cycle at E0+160; tx_busy high for exactly 160 cycles.
3. bd_rate=0, dnum=0, snum=1, par=1, data_in=8'hFF -> 7 data bits of 1 then parity bit=1 (seven ones, odd count), then 2 stop bits; frame is 11 bits * 32 = 352 cycles; data_in[7] does not appear on tx.
4. Hold tx_start high continuously with data 8'h00 then 8'h01, 8N1, bd_rate=1 -> two frames; exactly one idle-high cycle between the first stop bit end and the second start bit; second frame sends 1 then seven 0s.
5. Change data_in, bd_rate and par, and pulse tx_start, in the middle of a frame -> the frame in progress is bit-identical to one with unchanged inputs; the extra tx_start is ignored.
6. Assert rst during the 3rd data bit -> tx=1 and tx_ready=1 on the following cycle; no tx_done pulse; the next accepted frame is correct.
